axi_sb_master: RTL and testbench
================================

AXI_SB_MASTER -- requirements
Module: axi_sb_master

Interface
REQ-001 SHALL have parameter TXN_ID, default 0, meaning the AXI ID driven on awid/arid for every transaction.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  command request valid.
REQ-005 SHALL have port req_ready  output  1  command accepted when high with req_valid.
REQ-006 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  write data.
REQ-009 SHALL have port req_wstrb  input  4  write byte strobes.
REQ-010 SHALL have port rsp_valid  output  1  response valid, held until rsp_ready.
REQ-011 SHALL have port rsp_ready  input  1  response consumed.
REQ-012 SHALL have port rsp_rdata  output  32  read data; 0 for writes.
REQ-013 SHALL have port rsp_err  output  1  high when bresp/rresp was not OKAY (bit 1 set).
REQ-014 SHALL have port axi_mosi  output  s_axi_mosi_t  AXI initiator-to-responder channel bundle.
REQ-015 SHALL have port axi_miso  input  s_axi_miso_t  AXI responder-to-initiator channel bundle.

Function
REQ-016 SHALL implement states IDLE, WR (AW+W), WR_B, RD_A, RD_R, RSP; one transaction outstanding at a time.
REQ-017 SHALL assert req_ready only in IDLE; req_valid&&req_ready registers addr/wdata/wstrb/we and moves to WR (we=1) or RD_A (we=0) next cycle.
REQ-018 SHALL in WR drive awvalid and wvalid together from the first cycle; each deasserts in the cycle after its own handshake (awvalid&&awready, wvalid&&wready); ready may arrive in either order or together.
REQ-019 SHALL keep awaddr/awid/wdata/wstrb stable while the corresponding valid is high.
REQ-020 SHALL move WR->WR_B only after both AW and W handshakes completed; W handshake before AW SHALL be legal.
REQ-021 SHALL drive awlen/arlen=0, awsize/arsize=2 (4 bytes), awburst/arburst=INCR, wlast=1 with wvalid, all other mosi fields 0.
REQ-022 SHALL in WR_B drive bready=1; on bvalid capture bresp[1] as rsp_err, rsp_rdata=0, go to RSP.
REQ-023 SHALL in RD_A drive arvalid=1 with araddr/arid; on arready go to RD_R.
REQ-024 SHALL in RD_R drive rready=1; on rvalid capture rdata and rresp[1], go to RSP; rid and rlast are not checked.
REQ-025 SHALL in RSP hold rsp_valid=1 with stable rsp_rdata/rsp_err; on rsp_ready return to IDLE, so req_ready rises one cycle after response consumption (no same-cycle rsp->req overlap).
REQ-026 SHALL keep bready/rready low outside WR_B/RD_R; a stray bvalid/rvalid in other states is ignored.
REQ-027 SHALL give minimum latency req accept -> rsp_valid of 3 cycles for reads and writes with zero-wait responder.

Reset
REQ-028 SHALL on rst low immediately (asynchronously) enter IDLE and drive all mosi valids/readies, rsp_valid, rsp_err, rsp_rdata to 0 and req_ready to 0 while reset asserted.
REQ-029 SHALL assert req_ready in the first clock edge after rst deasserts; reset mid-transaction abandons it with no response issued.

Verification
REQ-030 Write 0x0000_0008 data 0xDEAD_BEEF strb 0xF, responder awready/wready same cycle, bresp=OKAY -> one AW, one W with wlast=1, rsp_valid with rsp_err=0, rsp_rdata=0.
REQ-031 Write with wready 2 cycles before awready -> wvalid drops after W handshake, awvalid held with stable awaddr until accepted, single response.
REQ-032 Read 0x0000_0004 with rdata 0x1234_5678 rresp=OKAY after 5 wait cycles -> rsp_rdata=0x1234_5678, rsp_err=0, arid=TXN_ID.
REQ-033 Read with rresp=SLVERR (2'b10) -> rsp_err=1; write with bresp=DECERR -> rsp_err=1.
REQ-034 rsp_ready held low 4 cycles -> rsp_valid/data stable, req_ready low, new req_valid not accepted until cycle after rsp_ready.
REQ-035 Assert rst low while in WR_B -> all outputs 0 same cycle, after release req_ready=1 and no rsp_valid.

Source files
------------

// File: rtl/axi_sb_master.sv
// rtl/axi_sb_master.sv - single-outstanding AXI4 initiator behind a simple request/response port
package axi_sb_pkg;
  localparam int ID_W = 4;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'd2;

  typedef struct packed {
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            bready;
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic            awready;
    logic            wready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
  } s_axi_miso_t;
endpackage

module axi_sb_master
  import axi_sb_pkg::*;
#(
  parameter logic [ID_W-1:0] TXN_ID = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output s_axi_mosi_t axi_mosi,
  input  s_axi_miso_t axi_miso
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_B, S_RD_A, S_RD_R, S_RSP} state_t;

  state_t      state, state_nxt;
  logic        run;
  logic        aw_done, w_done;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic        err_q;
  logic        req_hs, aw_hs, w_hs, b_hs, r_hs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    req_hs    = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    b_hs      = 1'b0;
    r_hs      = 1'b0;
    axi_mosi         = '0;
    axi_mosi.awid    = TXN_ID;
    axi_mosi.awaddr  = addr_q;
    axi_mosi.awsize  = SIZE_4B;
    axi_mosi.awburst = BURST_INCR;
    axi_mosi.wdata   = wdata_q;
    axi_mosi.wstrb   = wstrb_q;
    axi_mosi.arid    = TXN_ID;
    axi_mosi.araddr  = addr_q;
    axi_mosi.arsize  = SIZE_4B;
    axi_mosi.arburst = BURST_INCR;
    case (state)
      S_IDLE: begin
        // run keeps req_ready low until the first edge after reset release
        req_ready = run;
        req_hs    = req_valid && run;
        if (req_hs) state_nxt = req_we ? S_WR : S_RD_A;
      end
      S_WR: begin
        axi_mosi.awvalid = !aw_done;
        axi_mosi.wvalid  = !w_done;
        axi_mosi.wlast   = !w_done;
        aw_hs = !aw_done && axi_miso.awready;
        w_hs  = !w_done && axi_miso.wready;
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = S_WR_B;
      end
      S_WR_B: begin
        axi_mosi.bready = 1'b1;
        b_hs = axi_miso.bvalid;
        if (b_hs) state_nxt = S_RSP;
      end
      S_RD_A: begin
        axi_mosi.arvalid = 1'b1;
        if (axi_miso.arready) state_nxt = S_RD_R;
      end
      S_RD_R: begin
        axi_mosi.rready = 1'b1;
        r_hs = axi_miso.rvalid;
        if (r_hs) state_nxt = S_RSP;
      end
      S_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run     <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (req_hs) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (b_hs) begin
        rdata_q <= '0;
        err_q   <= axi_miso.bresp[1];
      end
      if (r_hs) begin
        rdata_q <= axi_miso.rdata;
        err_q   <= axi_miso.rresp[1];
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  logic unused_miso;
  assign unused_miso = ^{axi_miso.bid, axi_miso.bresp[0], axi_miso.rid,
                         axi_miso.rresp[0], axi_miso.rlast};

endmodule

// File: tb/tb_axi_sb_master.sv
// tb/tb_axi_sb_master.sv - randomized self-checking bench for axi_sb_master with a behavioural AXI responder
module tb_axi_sb_master;
  import axi_sb_pkg::*;

  localparam logic [ID_W-1:0] TID = 4'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  s_axi_mosi_t axi_mosi;
  s_axi_miso_t axi_miso;

  axi_sb_master #(.TXN_ID(TID)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .axi_mosi(axi_mosi), .axi_miso(axi_miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // responder configuration and per-transaction observations
  int          cfg_aw_d, cfg_w_d, cfg_b_d, cfg_ar_d, cfg_r_d;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [31:0] cfg_rdata;
  logic        stray_b = 1'b0, stray_r = 1'b0;
  int          aw_hs_n, w_hs_n, b_hs_n, ar_hs_n, r_hs_n;
  logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
  logic [3:0]  cap_wstrb;
  logic        cap_wlast;
  logic [ID_W-1:0] cap_awid, cap_arid;
  logic [12:0] cap_awctl, cap_arctl;
  logic [12:0] ctl_exp = {8'd0, 3'd2, 2'd1};

  initial begin : responder
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic aw_seen, w_seen, ar_seen, aw_dn, w_dn, b_pend, r_pend, bv, rv;
    logic [31:0] aw_last, w_last, ar_last;
    logic [3:0] ws_last;
    axi_miso = '0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_seen = 0; w_seen = 0; ar_seen = 0; aw_dn = 0; w_dn = 0; b_pend = 0; r_pend = 0;
    aw_last = '0; w_last = '0; ar_last = '0; ws_last = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        axi_miso = '0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_seen = 0; w_seen = 0; ar_seen = 0; aw_dn = 0; w_dn = 0; b_pend = 0; r_pend = 0;
      end else begin
        checks += 2;
        if (axi_mosi.bready && !b_pend) begin
          errors++; $display("FAIL bready_phase: bready=1 required 0 (no write response due) at cycle %0d", cyc);
        end
        if (axi_mosi.rready && !r_pend) begin
          errors++; $display("FAIL rready_phase: rready=1 required 0 (no read data due) at cycle %0d", cyc);
        end
        bv = 1'b0;
        if (b_pend) begin
          if (b_cnt >= cfg_b_d) bv = 1'b1; else b_cnt++;
        end
        axi_miso.bvalid = bv | stray_b;
        axi_miso.bresp  = cfg_bresp;
        axi_miso.bid    = TID;
        if (bv && axi_mosi.bready) begin b_hs_n++; b_pend = 0; b_cnt = 0; end
        rv = 1'b0;
        if (r_pend) begin
          if (r_cnt >= cfg_r_d) rv = 1'b1; else r_cnt++;
        end
        axi_miso.rvalid = rv | stray_r;
        axi_miso.rresp  = cfg_rresp;
        axi_miso.rdata  = cfg_rdata;
        axi_miso.rid    = TID;
        axi_miso.rlast  = 1'b1;
        if (rv && axi_mosi.rready) begin r_hs_n++; r_pend = 0; r_cnt = 0; end
        if (axi_mosi.awvalid) begin
          if (aw_seen) begin
            checks++;
            if (axi_mosi.awaddr !== aw_last) begin
              errors++; $display("FAIL awaddr_stable: awaddr=%h required %h", axi_mosi.awaddr, aw_last);
            end
          end
          aw_seen = 1; aw_last = axi_mosi.awaddr;
          if (aw_cnt >= cfg_aw_d) begin
            axi_miso.awready = 1'b1; aw_hs_n++; aw_dn = 1; aw_seen = 0; aw_cnt = 0;
            cap_awaddr = axi_mosi.awaddr; cap_awid = axi_mosi.awid;
            cap_awctl = {axi_mosi.awlen, axi_mosi.awsize, axi_mosi.awburst};
          end else begin
            axi_miso.awready = 1'b0; aw_cnt++;
          end
        end else begin
          axi_miso.awready = 1'b0; aw_seen = 0; aw_cnt = 0;
        end
        if (axi_mosi.wvalid) begin
          if (w_seen) begin
            checks++;
            if (axi_mosi.wdata !== w_last || axi_mosi.wstrb !== ws_last) begin
              errors++; $display("FAIL w_stable: wdata/wstrb=%h/%h required %h/%h",
                                 axi_mosi.wdata, axi_mosi.wstrb, w_last, ws_last);
            end
          end
          w_seen = 1; w_last = axi_mosi.wdata; ws_last = axi_mosi.wstrb;
          if (w_cnt >= cfg_w_d) begin
            axi_miso.wready = 1'b1; w_hs_n++; w_dn = 1; w_seen = 0; w_cnt = 0;
            cap_wdata = axi_mosi.wdata; cap_wstrb = axi_mosi.wstrb; cap_wlast = axi_mosi.wlast;
          end else begin
            axi_miso.wready = 1'b0; w_cnt++;
          end
        end else begin
          axi_miso.wready = 1'b0; w_seen = 0; w_cnt = 0;
        end
        if (aw_dn && w_dn) begin b_pend = 1; b_cnt = 0; aw_dn = 0; w_dn = 0; end
        if (axi_mosi.arvalid) begin
          if (ar_seen) begin
            checks++;
            if (axi_mosi.araddr !== ar_last) begin
              errors++; $display("FAIL araddr_stable: araddr=%h required %h", axi_mosi.araddr, ar_last);
            end
          end
          ar_seen = 1; ar_last = axi_mosi.araddr;
          if (ar_cnt >= cfg_ar_d) begin
            axi_miso.arready = 1'b1; ar_hs_n++; ar_seen = 0; ar_cnt = 0; r_pend = 1; r_cnt = 0;
            cap_araddr = axi_mosi.araddr; cap_arid = axi_mosi.arid;
            cap_arctl = {axi_mosi.arlen, axi_mosi.arsize, axi_mosi.arburst};
          end else begin
            axi_miso.arready = 1'b0; ar_cnt++;
          end
        end else begin
          axi_miso.arready = 1'b0; ar_seen = 0; ar_cnt = 0;
        end
      end
    end
  end

  // One complete transaction; expected response and latency come from the responder settings.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int aw_d, input int w_d, input int b_d,
                         input int ar_d, input int r_d, input logic [1:0] resp,
                         input logic [31:0] rdata, input int hold, input string tag);
    int t, acc, lat, exp_lat;
    logic exp_err;
    logic [31:0] exp_rdata;
    cfg_aw_d = aw_d; cfg_w_d = w_d; cfg_b_d = b_d; cfg_ar_d = ar_d; cfg_r_d = r_d;
    cfg_bresp = resp; cfg_rresp = resp; cfg_rdata = rdata;
    aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0; ar_hs_n = 0; r_hs_n = 0;
    exp_err   = resp[1];
    exp_rdata = we ? 32'h0 : rdata;
    exp_lat   = we ? (((aw_d > w_d) ? aw_d : w_d) + b_d + 3) : (ar_d + r_d + 3);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s accept: req_ready=%b required 1", tag, req_ready);
      req_valid = 1'b0;
      return;
    end
    acc = cyc;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    t = 0;
    while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
    lat = cyc - acc;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL %s rsp_timeout: rsp_valid=%b required 1", tag, rsp_valid);
      return;
    end
    checks += 3;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d required %0d", tag, lat, exp_lat);
    end
    if (rsp_rdata !== exp_rdata) begin
      errors++; $display("FAIL %s rsp_rdata: got %h required %h", tag, rsp_rdata, exp_rdata);
    end
    if (rsp_err !== exp_err) begin
      errors++; $display("FAIL %s rsp_err: got %b required %b", tag, rsp_err, exp_err);
    end
    for (int i = 0; i < hold; i++) begin
      checks += 4;
      if (rsp_valid !== 1'b1) begin
        errors++; $display("FAIL %s hold_valid: rsp_valid=%b required 1", tag, rsp_valid);
      end
      if (rsp_rdata !== exp_rdata) begin
        errors++; $display("FAIL %s hold_rdata: got %h required %h", tag, rsp_rdata, exp_rdata);
      end
      if (rsp_err !== exp_err) begin
        errors++; $display("FAIL %s hold_err: got %b required %b", tag, rsp_err, exp_err);
      end
      if (req_ready !== 1'b0) begin
        errors++; $display("FAIL %s hold_req_ready: got %b required 0", tag, req_ready);
      end
      req_valid = 1'b1; req_we = $urandom_range(0, 1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = 1'b0;
    checks += 2;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL %s rsp_drop: rsp_valid=%b required 0", tag, rsp_valid);
    end
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle_after_rsp: req_ready=%b required 1", tag, req_ready);
    end
    checks += 5;
    if (aw_hs_n != (we ? 1 : 0) || w_hs_n != (we ? 1 : 0) || b_hs_n != (we ? 1 : 0)) begin
      errors++; $display("FAIL %s write_beats: aw/w/b=%0d/%0d/%0d required %0d each", tag, aw_hs_n, w_hs_n, b_hs_n, we ? 1 : 0);
    end
    if (ar_hs_n != (we ? 0 : 1) || r_hs_n != (we ? 0 : 1)) begin
      errors++; $display("FAIL %s read_beats: ar/r=%0d/%0d required %0d each", tag, ar_hs_n, r_hs_n, we ? 0 : 1);
    end
    if (we) begin
      if (cap_awaddr !== addr || cap_awid !== TID) begin
        errors++; $display("FAIL %s aw_fields: addr/id=%h/%h required %h/%h", tag, cap_awaddr, cap_awid, addr, TID);
      end
      if (cap_awctl !== ctl_exp || cap_wlast !== 1'b1) begin
        errors++; $display("FAIL %s aw_ctl: len/size/burst=%h wlast=%b required %h and 1", tag, cap_awctl, cap_wlast, ctl_exp);
      end
      if (cap_wdata !== wdata || cap_wstrb !== strb) begin
        errors++; $display("FAIL %s w_fields: data/strb=%h/%h required %h/%h", tag, cap_wdata, cap_wstrb, wdata, strb);
      end
    end else begin
      if (cap_araddr !== addr || cap_arid !== TID) begin
        errors++; $display("FAIL %s ar_fields: addr/id=%h/%h required %h/%h", tag, cap_araddr, cap_arid, addr, TID);
      end
      if (cap_arctl !== ctl_exp) begin
        errors++; $display("FAIL %s ar_ctl: len/size/burst=%h required %h", tag, cap_arctl, ctl_exp);
      end
      checks++;
      if (axi_mosi.awvalid !== 1'b0 || axi_mosi.wvalid !== 1'b0) begin
        errors++; $display("FAIL %s read_no_write: awvalid/wvalid=%b/%b required 0/0", tag, axi_mosi.awvalid, axi_mosi.wvalid);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_wstrb = '0; rsp_ready = 1'b0;
    cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0; cfg_ar_d = 0; cfg_r_d = 0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = '0;
    #2 rst = 1'b0;
    #1;
    checks += 3;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: req_ready/rsp_valid=%b/%b required 0/0", req_ready, rsp_valid);
    end
    if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_data: rsp_err/rsp_rdata=%b/%h required 0/0", rsp_err, rsp_rdata);
    end
    if ({axi_mosi.awvalid, axi_mosi.wvalid, axi_mosi.bready, axi_mosi.arvalid, axi_mosi.rready} !== 5'b0) begin
      errors++; $display("FAIL reset_axi: aw/w/b/ar/r=%b%b%b%b%b required 00000", axi_mosi.awvalid,
                         axi_mosi.wvalid, axi_mosi.bready, axi_mosi.arvalid, axi_mosi.rready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_held: req_ready=%b required 0", req_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_release_pre_edge: req_ready=%b required 0", req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_edge: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_write_basic;
    run_txn(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0, "write_basic");
  endtask

  task automatic test_w_before_aw;
    run_txn(1'b1, 32'h0000_0100, 32'hA5A5_0F0F, 4'h3, 2, 0, 0, 0, 0, 2'b00, 32'h0, 0, "w_before_aw");
    run_txn(1'b1, 32'h0000_0200, 32'h0123_4567, 4'hC, 0, 3, 1, 0, 0, 2'b00, 32'h0, 0, "aw_before_w");
  endtask

  task automatic test_read_wait;
    run_txn(1'b0, 32'h0000_0004, 32'h0, 4'h0, 0, 0, 0, 0, 5, 2'b00, 32'h1234_5678, 0, "read_wait");
  endtask

  task automatic test_error_resp;
    run_txn(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, 0, 2'b11, 32'h0, 0, "write_decerr");
    run_txn(1'b0, 32'h0000_0044, 32'h0, 4'h0, 0, 0, 0, 1, 0, 2'b10, 32'h8765_4321, 0, "read_slverr");
  endtask

  task automatic test_reset_mid;
    int t;
    cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 40; cfg_bresp = 2'b00;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0080; req_wdata = 32'h5555_AAAA; req_wstrb = 4'hF;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (!axi_mosi.bready && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (axi_mosi.bready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_reach_wr_b: bready=%b required 1", axi_mosi.bready);
    end
    #2 rst = 1'b0;
    #1;
    checks += 3;
    if ({axi_mosi.awvalid, axi_mosi.wvalid, axi_mosi.bready, axi_mosi.arvalid, axi_mosi.rready} !== 5'b0) begin
      errors++; $display("FAIL reset_mid_axi: aw/w/b/ar/r=%b%b%b%b%b required 00000", axi_mosi.awvalid,
                         axi_mosi.wvalid, axi_mosi.bready, axi_mosi.arvalid, axi_mosi.rready);
    end
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_handshake: req_ready/rsp_valid=%b/%b required 0/0", req_ready, rsp_valid);
    end
    if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_mid_data: rsp_err/rsp_rdata=%b/%h required 0/0", rsp_err, rsp_rdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_release: req_ready=%b required 1", req_ready);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL reset_mid_no_rsp: rsp_valid=%b required 0", rsp_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    run_txn(1'b1, 32'h0000_0010, 32'h1111_2222, 4'h5, 1, 0, 0, 0, 0, 2'b00, 32'h0, 4, "bp_write");
    run_txn(1'b0, 32'h0000_0014, 32'h0, 4'h0, 0, 0, 0, 0, 2, 2'b00, 32'h3333_4444, 4, "bp_read");
  endtask

  task automatic test_stray;
    @(negedge clk);
    stray_b = 1'b1; stray_r = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks += 2;
      if (axi_mosi.bready !== 1'b0 || axi_mosi.rready !== 1'b0) begin
        errors++; $display("FAIL stray_ready: bready/rready=%b/%b required 0/0", axi_mosi.bready, axi_mosi.rready);
      end
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL stray_state: rsp_valid/req_ready=%b/%b required 0/1", rsp_valid, req_ready);
      end
    end
    stray_b = 1'b0; stray_r = 1'b0;
    @(negedge clk);
    run_txn(1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h0BAD_CAFE, 0, "after_stray");
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      run_txn($urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)),
              $urandom, $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_write_basic;
    test_w_before_aw;
    test_read_wait;
    test_error_resp;
    test_reset_mid;
    test_backpressure;
    test_stray;
    test_random;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
